// File: rtl/param_sync_fifo_if.sv
// Bundle of the data and status signals of param_sync_fifo. Clock and reset
// stay as plain ports on the FIFO itself.
interface param_sync_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: write/read are requests sampled at the rising clock edge. A write
  // is taken when full is low and a read when empty is low, using the flags as
  // they stood before that edge. A refused request leaves the contents alone and
  // sets the matching sticky error flag.
  logic             write;
  logic [WIDTH-1:0] din;
  logic             read;
  logic             clear_err;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    data_count;
  logic             overflow;
  logic             underflow;

  modport master (
    output write, din, read, clear_err,
    input  dout, full, empty, almost_full, almost_empty, data_count,
           overflow, underflow
  );

  modport slave (
    input  write, din, read, clear_err,
    output dout, full, empty, almost_full, almost_empty, data_count,
           overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered status flags, programmable almost thresholds,
// optional first-word-fall-through read and sticky overflow/underflow flags.
module param_sync_fifo #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic               clk_125M,
  input  logic               reset,
  param_sync_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;

  always_comb begin
    wr_acc = bus.write & ~full_q;
    rd_acc = bus.read & ~empty_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are derived from the next count so they line up with data_count.
  always_comb begin
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  // A new error in the same cycle as clear_err keeps the flag set.
  always_comb begin
    overflow_d  = (bus.write & full_q)  | (overflow_q  & ~bus.clear_err);
    underflow_d = (bus.read  & empty_q) | (underflow_q & ~bus.clear_err);
  end

  always_ff @(posedge clk_125M or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk_125M) begin
    if (wr_acc && reset) mem[wr_ptr_q] <= bus.din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout = empty_q ? '0 : mem[rd_ptr_q];
    end else begin : g_std
      logic [WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem[rd_ptr_q];
      end

      always_ff @(posedge clk_125M or negedge reset) begin
        if (!reset) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      assign bus.dout = dout_q;
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.data_count   = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  cfg_thresh_a: assert property (@(posedge clk_125M)
    (AF_THRESH >= 0) && (AF_THRESH <= DEPTH) &&
    (AE_THRESH >= 0) && (AE_THRESH <= DEPTH))
    else $error("param_sync_fifo: almost threshold outside 0..DEPTH");

  cfg_depth_a: assert property (@(posedge clk_125M)
    (DEPTH >= 4) && ((DEPTH & (DEPTH - 1)) == 0))
    else $error("param_sync_fifo: DEPTH must be a power of two >= 4");
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a standard-read instance (a) and an FWFT
// instance (b) sharing clock and reset.
module tb_param_sync_fifo;
  logic clk_125M = 1'b0;
  logic reset    = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  logic [3:0] exp_q[$];

  always #4 clk_125M = ~clk_125M;

  param_sync_fifo_if #(.WIDTH(4), .DEPTH(16)) a ();
  param_sync_fifo_if #(.WIDTH(4), .DEPTH(16)) b ();

  param_sync_fifo #(.WIDTH(4), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut_a (
    .clk_125M (clk_125M),
    .reset    (reset),
    .bus      (a.slave)
  );

  param_sync_fifo #(.WIDTH(4), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_b (
    .clk_125M (clk_125M),
    .reset    (reset),
    .bus      (b.slave)
  );

  // {full, empty, almost_full, almost_empty, overflow, underflow}
  logic [5:0] st_a, st_b;
  assign st_a = {a.full, a.empty, a.almost_full, a.almost_empty, a.overflow, a.underflow};
  assign st_b = {b.full, b.empty, b.almost_full, b.almost_empty, b.overflow, b.underflow};

  task automatic drive_a(input logic w, input logic [3:0] d, input logic r, input logic c);
    a.write = w; a.din = d; a.read = r; a.clear_err = c;
    @(posedge clk_125M); #1;
    a.write = 1'b0; a.read = 1'b0; a.clear_err = 1'b0;
  endtask

  task automatic drive_b(input logic w, input logic [3:0] d, input logic r);
    b.write = w; b.din = d; b.read = r; b.clear_err = 1'b0;
    @(posedge clk_125M); #1;
    b.write = 1'b0; b.read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk_125M);
    #1;
    checks++;
    if (a.data_count !== 5'd0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", a.data_count);
    end
    checks++;
    if (st_a !== 6'b010100) begin
      errors++; $display("FAIL reset_status got=%b exp=010100", st_a);
    end
    checks++;
    if (a.dout !== 4'h0) begin
      errors++; $display("FAIL reset_dout got=%h exp=0", a.dout);
    end
    checks++;
    if (b.dout !== 4'h0 || st_b !== 6'b010100) begin
      errors++; $display("FAIL reset_fwft got dout=%h st=%b exp dout=0 st=010100", b.dout, st_b);
    end
    reset = 1'b1;
    @(posedge clk_125M); #1;
  endtask

  task automatic test_fill();
    logic [5:0] exp_st;
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 4'(i + 1), 1'b0, 1'b0);
      exp_q.push_back(4'(i + 1));
      exp_st = {(i == 15), 1'b0, (i + 1 >= 14), (i + 1 <= 2), 1'b0, 1'b0};
      checks++;
      if (a.data_count !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, a.data_count, i + 1);
      end
      checks++;
      if (st_a !== exp_st) begin
        errors++; $display("FAIL fill_status[%0d] got=%b exp=%b", i, st_a, exp_st);
      end
    end
    drive_a(1'b1, 4'h5, 1'b0, 1'b0);
    checks++;
    if (a.data_count !== 5'd16 || st_a !== 6'b101010) begin
      errors++; $display("FAIL overflow_write got cnt=%0d st=%b exp cnt=16 st=101010", a.data_count, st_a);
    end
  endtask

  task automatic test_drain();
    logic [3:0] exp_d;
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
    checks++;
    if (a.overflow !== 1'b0) begin
      errors++; $display("FAIL clear_overflow got=%b exp=0", a.overflow);
    end
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b0, 4'h0, 1'b1, 1'b0);
      exp_d = exp_q.pop_front();
      checks++;
      if (a.dout !== exp_d) begin
        errors++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, a.dout, exp_d);
      end
      checks++;
      if (a.data_count !== 5'(15 - i)) begin
        errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, a.data_count, 15 - i);
      end
    end
    checks++;
    if (st_a !== 6'b010100) begin
      errors++; $display("FAIL drain_empty got=%b exp=010100", st_a);
    end
    drive_a(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if (st_a !== 6'b010101 || a.dout !== 4'h0 || a.data_count !== 5'd0) begin
      errors++; $display("FAIL underflow_read got st=%b dout=%h cnt=%0d exp st=010101 dout=0 cnt=0",
                         st_a, a.dout, a.data_count);
    end
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d;
    logic [3:0] wd;
    for (int i = 0; i < 8; i++) begin
      wd = 4'(i * 3 + 2);
      drive_a(1'b1, wd, 1'b0, 1'b0);
      exp_q.push_back(wd);
    end
    checks++;
    if (a.data_count !== 5'd8) begin
      errors++; $display("FAIL b2b_prefill got=%0d exp=8", a.data_count);
    end
    for (int i = 0; i < 40; i++) begin
      wd = 4'(i * 7 + 5);
      drive_a(1'b1, wd, 1'b1, 1'b0);
      exp_d = exp_q.pop_front();
      exp_q.push_back(wd);
      checks++;
      if (a.dout !== exp_d || a.data_count !== 5'd8) begin
        errors++; $display("FAIL b2b[%0d] got dout=%h cnt=%0d exp dout=%h cnt=8", i, a.dout, a.data_count, exp_d);
      end
    end
    checks++;
    if (st_a !== 6'b000000) begin
      errors++; $display("FAIL b2b_status got=%b exp=000000", st_a);
    end
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b0, 4'h0, 1'b1, 1'b0);
      exp_d = exp_q.pop_front();
      checks++;
      if (a.dout !== exp_d) begin
        errors++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, a.dout, exp_d);
      end
    end
    checks++;
    if (a.empty !== 1'b1) begin
      errors++; $display("FAIL b2b_empty got=%b exp=1", a.empty);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_d;
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 4'(i ^ 5), 1'b0, 1'b0);
      exp_q.push_back(4'(i ^ 5));
    end
    drive_a(1'b1, 4'h9, 1'b1, 1'b0);
    exp_d = exp_q.pop_front();
    checks++;
    if (a.data_count !== 5'd15 || st_a !== 6'b001010 || a.dout !== exp_d) begin
      errors++; $display("FAIL rw_at_full got cnt=%0d st=%b dout=%h exp cnt=15 st=001010 dout=%h",
                         a.data_count, st_a, a.dout, exp_d);
    end
    for (int i = 0; i < 15; i++) begin
      drive_a(1'b0, 4'h0, 1'b1, 1'b0);
      exp_d = exp_q.pop_front();
      checks++;
      if (a.dout !== exp_d) begin
        errors++; $display("FAIL rw_drain[%0d] got=%h exp=%h", i, a.dout, exp_d);
      end
    end
    drive_a(1'b1, 4'hC, 1'b1, 1'b0);
    checks++;
    if (a.data_count !== 5'd1 || st_a !== 6'b000111) begin
      errors++; $display("FAIL rw_at_empty got cnt=%0d st=%b exp cnt=1 st=000111", a.data_count, st_a);
    end
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
    checks++;
    if (st_a !== 6'b000100 || a.data_count !== 5'd1) begin
      errors++; $display("FAIL clear_err got st=%b cnt=%0d exp st=000100 cnt=1", st_a, a.data_count);
    end
    for (int i = 0; i < 15; i++) drive_a(1'b1, 4'(i), 1'b0, 1'b0);
    checks++;
    if (st_a !== 6'b101000) begin
      errors++; $display("FAIL refill_full got=%b exp=101000", st_a);
    end
    drive_a(1'b1, 4'h7, 1'b0, 1'b1);
    checks++;
    if (a.overflow !== 1'b1 || a.data_count !== 5'd16) begin
      errors++; $display("FAIL set_beats_clear got ovf=%b cnt=%0d exp ovf=1 cnt=16", a.overflow, a.data_count);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 9; i++) drive_a(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if (a.data_count !== 5'd7) begin
      errors++; $display("FAIL pre_reset_count got=%0d exp=7", a.data_count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (a.data_count !== 5'd0 || st_a !== 6'b010100 || a.dout !== 4'h0) begin
      errors++; $display("FAIL midstream_reset got cnt=%0d st=%b dout=%h exp cnt=0 st=010100 dout=0",
                         a.data_count, st_a, a.dout);
    end
    a.write = 1'b1; a.din = 4'hE;
    @(posedge clk_125M); #1;
    a.write = 1'b0;
    reset = 1'b1;
    @(posedge clk_125M); #1;
    drive_a(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if (st_a !== 6'b010101 || a.data_count !== 5'd0 || a.dout !== 4'h0) begin
      errors++; $display("FAIL post_reset_read got st=%b cnt=%0d dout=%h exp st=010101 cnt=0 dout=0",
                         st_a, a.data_count, a.dout);
    end
  endtask

  task automatic test_fwft();
    drive_b(1'b1, 4'hA, 1'b0);
    checks++;
    if (b.empty !== 1'b0 || b.dout !== 4'hA || b.data_count !== 5'd1) begin
      errors++; $display("FAIL fwft_first got empty=%b dout=%h cnt=%0d exp empty=0 dout=a cnt=1",
                         b.empty, b.dout, b.data_count);
    end
    drive_b(1'b0, 4'h0, 1'b1);
    checks++;
    if (b.empty !== 1'b1 || b.dout !== 4'h0) begin
      errors++; $display("FAIL fwft_pop got empty=%b dout=%h exp empty=1 dout=0", b.empty, b.dout);
    end
    drive_b(1'b1, 4'h3, 1'b0);
    drive_b(1'b1, 4'h6, 1'b0);
    checks++;
    if (b.dout !== 4'h3 || b.data_count !== 5'd2) begin
      errors++; $display("FAIL fwft_head got dout=%h cnt=%0d exp dout=3 cnt=2", b.dout, b.data_count);
    end
    drive_b(1'b0, 4'h0, 1'b1);
    checks++;
    if (b.dout !== 4'h6 || b.data_count !== 5'd1) begin
      errors++; $display("FAIL fwft_next got dout=%h cnt=%0d exp dout=6 cnt=1", b.dout, b.data_count);
    end
  endtask

  initial begin
    a.write = 1'b0; a.din = 4'h0; a.read = 1'b0; a.clear_err = 1'b0;
    b.write = 1'b0; b.din = 4'h0; b.read = 1'b0; b.clear_err = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_simultaneous();
    test_reset_midstream();
    test_fwft();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
